// File: rtl/seq_alloc.sv
// Round-robin sequence-number allocator: N requesters share one W-bit counter, result in a registered valid/ready slot.
// Optional epoch bit tracking counter wraps is enabled by defining SEQ_ALLOC_EPOCH_EN.
module seq_alloc #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   gnt_o,
  input  logic           clear_i,
  output logic           rsp_vld_o,
  input  logic           rsp_rdy_i,
  output logic [IDW-1:0] rsp_id_o,
  output logic [W-1:0]   rsp_seq_o,
`ifdef SEQ_ALLOC_EPOCH_EN
  output logic           rsp_epoch_o,
`endif
  output logic           rsp_wrap_o
);

  typedef struct packed {
    logic         carry;
    logic [W-1:0] y;
  } inc_t;

  function automatic inc_t inc(input logic [W-1:0] a);
    inc_t r;
    {r.carry, r.y} = {1'b0, a} + {{W{1'b0}}, 1'b1};
    return r;
  endfunction

  logic [W-1:0]   cnt_r;
  logic [IDW-1:0] rr_ptr_r;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] nxt_ptr;
  logic           found;
  logic           accept;
  logic [W-1:0]   seq_base;
  inc_t           inc_res;

  // Scan upward from the round-robin pointer; first set request wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[(int'(rr_ptr_r) + i) % N]) begin
        winner = IDW'((int'(rr_ptr_r) + i) % N);
        found  = 1'b1;
      end
    end
  end

  assign accept   = found & (~rsp_vld_o | rsp_rdy_i) & ~rst;
  assign nxt_ptr  = (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;
  assign seq_base = clear_i ? '0 : cnt_r;
  assign inc_res  = inc(seq_base);

  always_comb begin
    gnt_o = '0;
    if (accept) gnt_o[winner] = 1'b1;
  end

`ifdef SEQ_ALLOC_EPOCH_EN
  logic epoch_r;
  logic epoch_base;
  assign epoch_base = clear_i ? 1'b0 : epoch_r;
`endif

  // Response slot stage: new allocation replaces a consumed response on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= '0;
      rr_ptr_r   <= '0;
      rsp_vld_o  <= 1'b0;
      rsp_id_o   <= '0;
      rsp_seq_o  <= '0;
      rsp_wrap_o <= 1'b0;
`ifdef SEQ_ALLOC_EPOCH_EN
      epoch_r     <= 1'b0;
      rsp_epoch_o <= 1'b0;
`endif
    end else if (accept) begin
      cnt_r      <= inc_res.y;
      rr_ptr_r   <= nxt_ptr;
      rsp_vld_o  <= 1'b1;
      rsp_id_o   <= winner;
      rsp_seq_o  <= seq_base;
      rsp_wrap_o <= inc_res.carry;
`ifdef SEQ_ALLOC_EPOCH_EN
      rsp_epoch_o <= epoch_base;
      epoch_r     <= epoch_base ^ inc_res.carry;
`endif
    end else begin
      if (clear_i) begin
        cnt_r <= '0;
`ifdef SEQ_ALLOC_EPOCH_EN
        epoch_r <= 1'b0;
`endif
      end
      if (rsp_rdy_i) rsp_vld_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alloc.sv
// Directed bench for seq_alloc: expected responses are queued at grant time and compared when the slot shows them.
module tb_seq_alloc;

  localparam int N = 4;
  localparam int W = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_i;
  logic [N-1:0]   gnt_o;
  logic           clear_i;
  logic           rsp_vld_o;
  logic           rsp_rdy_i;
  logic [IDW-1:0] rsp_id_o;
  logic [W-1:0]   rsp_seq_o;
  logic           rsp_wrap_o;
`ifdef SEQ_ALLOC_EPOCH_EN
  logic           rsp_epoch_o;
`endif

  seq_alloc #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .clear_i    (clear_i),
    .rsp_vld_o  (rsp_vld_o),
    .rsp_rdy_i  (rsp_rdy_i),
    .rsp_id_o   (rsp_id_o),
    .rsp_seq_o  (rsp_seq_o),
`ifdef SEQ_ALLOC_EPOCH_EN
    .rsp_epoch_o(rsp_epoch_o),
`endif
    .rsp_wrap_o (rsp_wrap_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   seq;
    logic           wrap;
    logic           epoch;
  } rsp_t;

  rsp_t         sb[$];
  int           checks = 0;
  int           fails  = 0;
  logic [W-1:0] m_cnt;
  logic         m_vld;
  logic         m_ep;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [N-1:0] req);
    rst = 1'b1; req_i = req; rsp_rdy_i = 1'b1; clear_i = 1'b0;
    #3;
    chk("gnt_in_reset", 32'(gnt_o), 32'h0);
    @(posedge clk); #1;
    chk("rst_vld", 32'(rsp_vld_o), 32'h0);
    chk("rst_id", 32'(rsp_id_o), 32'h0);
    chk("rst_seq", 32'(rsp_seq_o), 32'h0);
    chk("rst_wrap", 32'(rsp_wrap_o), 32'h0);
    sb.delete();
    m_cnt = '0; m_vld = 1'b0; m_ep = 1'b0;
    rst = 1'b0; req_i = '0;
  endtask

  // One clock: drive, check grant mid-cycle, update scoreboard, check slot after the edge.
  task automatic cycle(input logic [N-1:0] req, input logic rdy, input logic clr,
                       input logic [N-1:0] exp_gnt);
    rsp_t         e;
    logic [W-1:0] base;
    logic         ebase;
    req_i = req; rsp_rdy_i = rdy; clear_i = clr;
    #3;
    chk("gnt", 32'(gnt_o), 32'(exp_gnt));
    if (m_vld && rdy && sb.size() > 0) void'(sb.pop_front());
    if (exp_gnt != '0) begin
      base  = clr ? '0 : m_cnt;
      ebase = clr ? 1'b0 : m_ep;
      e.id = '0;
      for (int i = 0; i < N; i++) if (exp_gnt[i]) e.id = IDW'(i);
      e.seq   = base;
      e.wrap  = (base == {W{1'b1}});
      e.epoch = ebase;
      sb.push_back(e);
      m_cnt = base + 1'b1;
      m_ep  = ebase ^ e.wrap;
      m_vld = 1'b1;
    end else begin
      if (clr) begin m_cnt = '0; m_ep = 1'b0; end
      if (rdy) m_vld = 1'b0;
    end
    @(posedge clk); #1;
    chk("rsp_vld", 32'(rsp_vld_o), 32'(m_vld));
    if (m_vld) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'h1, 32'h0);
      end else begin
        chk("rsp_id", 32'(rsp_id_o), 32'(sb[0].id));
        chk("rsp_seq", 32'(rsp_seq_o), 32'(sb[0].seq));
        chk("rsp_wrap", 32'(rsp_wrap_o), 32'(sb[0].wrap));
`ifdef SEQ_ALLOC_EPOCH_EN
        chk("rsp_epoch", 32'(rsp_epoch_o), 32'(sb[0].epoch));
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_i = '0; rsp_rdy_i = 1'b0; clear_i = 1'b0;
    m_cnt = '0; m_vld = 1'b0; m_ep = 1'b0;
    @(posedge clk); #1;
    do_reset(4'b1111);

    // Single requester: seq 0,1,2 to id 0
    repeat (3) cycle(4'b0001, 1'b1, 1'b0, 4'b0001);
    cycle(4'b0000, 1'b1, 1'b0, 4'b0000);

    // All requesting from pointer 0: grants rotate 0,1,2,3,0
    do_reset(4'b0000);
    cycle(4'b1111, 1'b1, 1'b0, 4'b0001);
    cycle(4'b1111, 1'b1, 1'b0, 4'b0010);
    cycle(4'b1111, 1'b1, 1'b0, 4'b0100);
    cycle(4'b1111, 1'b1, 1'b0, 4'b1000);
    cycle(4'b1111, 1'b1, 1'b0, 4'b0001);

    // Backpressure: slot held, no grant, then grant in the cycle ready returns
    repeat (3) cycle(4'b0010, 1'b0, 1'b0, 4'b0000);
    cycle(4'b0010, 1'b1, 1'b0, 4'b0010);
    cycle(4'b0000, 1'b1, 1'b0, 4'b0000);

    // Advance counter to 37, then clear with accept, then clear alone
    repeat (31) cycle(4'b0100, 1'b1, 1'b0, 4'b0100);
    chk("cnt_before_clear", 32'(m_cnt), 32'd37);
    cycle(4'b0100, 1'b1, 1'b1, 4'b0100);
    chk("clear_accept_seq", 32'(rsp_seq_o), 32'd0);
    cycle(4'b0100, 1'b1, 1'b0, 4'b0100);
    chk("after_clear_seq", 32'(rsp_seq_o), 32'd1);
    cycle(4'b0000, 1'b1, 1'b1, 4'b0000);
    cycle(4'b0100, 1'b1, 1'b0, 4'b0100);
    chk("clear_alone_seq", 32'(rsp_seq_o), 32'd0);

    // Wrap: run to seq 255, then seq 0
    repeat (254) cycle(4'b0100, 1'b1, 1'b0, 4'b0100);
    cycle(4'b0100, 1'b1, 1'b0, 4'b0100);
    chk("wrap_seq", 32'(rsp_seq_o), 32'd255);
    chk("wrap_flag", 32'(rsp_wrap_o), 32'd1);
`ifdef SEQ_ALLOC_EPOCH_EN
    chk("wrap_epoch", 32'(rsp_epoch_o), 32'd0);
`endif
    cycle(4'b0100, 1'b1, 1'b0, 4'b0100);
    chk("post_wrap_seq", 32'(rsp_seq_o), 32'd0);
    chk("post_wrap_flag", 32'(rsp_wrap_o), 32'd0);
`ifdef SEQ_ALLOC_EPOCH_EN
    chk("post_wrap_epoch", 32'(rsp_epoch_o), 32'd1);
`endif

    // Reset mid-operation with a pending response and cnt 10
    repeat (9) cycle(4'b0100, 1'b1, 1'b0, 4'b0100);
    chk("cnt_before_rst", 32'(m_cnt), 32'd10);
    chk("vld_before_rst", 32'(rsp_vld_o), 32'd1);
    do_reset(4'b0100);
    cycle(4'b1010, 1'b1, 1'b0, 4'b0010);
    chk("first_after_rst_seq", 32'(rsp_seq_o), 32'd0);
    chk("first_after_rst_id", 32'(rsp_id_o), 32'd1);
    cycle(4'b0000, 1'b1, 1'b0, 4'b0000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_alloc.md
Name: seq_alloc

Overview:
Round-robin allocator that shares one W-bit sequence counter, built on the common `inc` incrementer, among N requesters. Each accepted request receives the current counter value as a unique sequence number; the counter then advances by one. The result is returned through a single registered response slot with valid/ready backpressure. It sits in front of any unit needing ordered tags (transaction IDs, ticket numbers).

Parameters:
N, 4, number of requesters (N >= 2)
W, 8, sequence-number width (W >= 1)
IDW, $clog2(N), width of requester index (derived localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  N  per-requester request level; held until granted
gnt_o  out  N  one-hot grant; combinational; high in the cycle the request is accepted
clear_i  in  1  synchronous counter clear
rsp_vld_o  out  1  response slot valid
rsp_rdy_i  in  1  consumer accepts response
rsp_id_o  out  IDW  index of granted requester
rsp_seq_o  out  W  allocated sequence number
rsp_wrap_o  out  1  this allocation wrapped the counter (inc carry out)

Behaviour:
- Single clock `clk`; reset `rst` is synchronous, active-high.
- State: cnt_r[W], rr_ptr_r[IDW], response register (vld, id, seq, wrap).
- Reset values: cnt_r=0, rr_ptr_r=0, rsp_vld_o=0, rsp_id_o=0, rsp_seq_o=0, rsp_wrap_o=0. gnt_o=0 while rst is high.
- Slot free: accept = (|req_i) & (~rsp_vld_o | rsp_rdy_i). Full-throughput: one allocation per cycle while the consumer is ready.
- Arbitration: pick the first set req_i at or after rr_ptr_r, scanning upward modulo N. gnt_o is one-hot on that index only when accept=1, otherwise all zero. On accept, rr_ptr_r is set to (winner+1) mod N. The pointer holds when there is no accept.
- Allocation on accept:
  - rsp_seq_o <= seq_base, where seq_base = clear_i ? 0 : cnt_r.
  - cnt_r <= inc(seq_base).y.
  - rsp_wrap_o <= inc(seq_base).carry.
  - rsp_id_o <= winner; rsp_vld_o <= 1.
- Latency: request granted in cycle T → response visible in cycle T+1.
- Response register:
  - Holds stable while rsp_vld_o & ~rsp_rdy_i; no accept in that case, all gnt_o = 0.
  - rsp_rdy_i & ~accept → rsp_vld_o <= 0.
  - rsp_rdy_i & accept → new response replaces the old one in the same edge.
- clear_i without accept: cnt_r <= 0. With accept, the granted requester gets seq 0 and cnt_r <= 1. clear_i does not touch rr_ptr_r or a pending response.
- Wrap-around: cnt_r = 2^W-1 is allocated with rsp_wrap_o=1, and cnt_r becomes 0. No allocation is refused at wrap.
- Requests deasserted before grant are dropped silently. The block does not check for duplicate outstanding sequence numbers.
- Reset mid-operation: any pending response is discarded and the counter and pointer return to 0 on the next edge.

Optional Feature:
SEQ_ALLOC_EPOCH_EN
- Defined: adds output rsp_epoch_o (1 bit) and register epoch_r, reset 0.
  - epoch_r toggles on every accept whose inc carry=1.
  - rsp_epoch_o carries the epoch value in effect for that allocation (the pre-toggle value).
  - clear_i also resets epoch_r to 0.
- Undefined: no port and no register. Behaviour is otherwise identical.

Test Plan:
- Reset, then N=4, W=8, req_i=4'b0001 for 3 cycles, rsp_rdy_i=1 → gnt_o=0001 each cycle; responses id=0 with seq 0,1,2 in cycles T+1..T+3; rsp_wrap_o=0.
- req_i=4'b1111 held, rsp_rdy_i=1, from rr_ptr=0 → grants 0,1,2,3,0 in consecutive cycles; seq increments by 1 each cycle; no starvation.
- Backpressure: rsp_vld_o=1 and rsp_rdy_i=0 for 3 cycles with req_i=0010 → gnt_o=0 and response held stable; rsp_rdy_i=1 → grant issued that same cycle, new response the next cycle.
- Wrap: force 255 allocations, then one more → seq=255 with rsp_wrap_o=1, next seq=0 with wrap=0. With SEQ_ALLOC_EPOCH_EN: epoch 0 for seq 255, 1 for the following seq 0.
- clear_i with simultaneous accept while cnt_r=37 → rsp_seq_o=0, next allocation seq=1. clear_i alone → next allocation seq=0.
- Assert rst while rsp_vld_o=1 and cnt_r=10 → next cycle rsp_vld_o=0; first allocation after reset is seq 0 to the lowest-index requester.
